bus_arbiter: RTL and testbench

Main-bus arbiter for Tom. It shares the external memory bus between up to `NREQ` bus masters: the 68000 interface, GPU, blitter, object processor and DSP. Exactly one master is granted at a time, and ownership is tracked cycle by cycle through a start/ack handshake with the memory controller. Owners are preempted at cycle boundaries by higher-priority masters or when they exceed their hold allowance. The one-hot grant drives the tristate enables (`w`, `rw`, `mreq`, `justify`) of each master's bus interface.

---
 rtl/bus_arb_pkg.sv | 22 ++
 rtl/bus_arb_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 123 ++++++++++++
 tb/tb_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the main-bus arbiter.
package bus_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_CYCLE   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Default width of each requester's static priority field.
  localparam int PRIO_W_DEF = 2;

  // Request-line index of each bus master.
  localparam int M_68K  = 0;
  localparam int M_GPU  = 1;
  localparam int M_BLIT = 2;
  localparam int M_OP   = 3;
  localparam int M_DSP  = 4;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner select: highest priority among active requests,
// ties resolved round-robin starting just after the last winner.
module bus_arb_pick #(
  parameter int NREQ   = 4,
  parameter int PRIO_W = 2,
  parameter int IW     = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*PRIO_W-1:0] prio,
  input  logic [IW-1:0]          rr_ptr,
  output logic [IW-1:0]          win_idx,
  output logic                   win_valid
);

  logic [PRIO_W-1:0] best_p;
  int                idx;

  // Scan from rr_ptr+1 around the ring; only a strictly higher priority
  // displaces an earlier candidate, so the first of equals in scan order wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best_p    = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req[idx] && (!win_valid || (prio[idx*PRIO_W +: PRIO_W] > best_p))) begin
        win_valid = 1'b1;
        win_idx   = IW'(idx);
        best_p    = prio[idx*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Main-bus arbiter: one-hot grant, cycle tracking via start/ack,
// preemption by priority or hold allowance, and a grant timeout.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int PRIO_W   = PRIO_W_DEF,
  parameter int HOLD_MAX = 8,
  parameter int GRANT_TO = 16
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*PRIO_W-1:0]    prio,
  input  logic [NREQ-1:0]           cyc_start,
  input  logic                      ack,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      owner_valid,
  output logic                      bus_busy,
  output logic                      preempt
);

  localparam int IW  = $clog2(NREQ);
  localparam int HW  = $clog2(HOLD_MAX + 1);
  localparam int TOW = $clog2(GRANT_TO + 1);

  arb_state_e       state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    rr_q;
  logic [HW-1:0]    hold_q, hold_d;
  logic [TOW-1:0]   to_q;

  logic [IW-1:0]     win_idx;
  logic              win_valid;
  logic [NREQ-1:0]   others;
  logic [PRIO_W-1:0] own_p;
  logic              hi_other;
  logic              pre_after_ack;
  logic              cs_own, req_own;

  bus_arb_pick #(.NREQ(NREQ), .PRIO_W(PRIO_W), .IW(IW)) u_pick (
    .req       (req),
    .prio      (prio),
    .rr_ptr    (rr_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // Preemption terms; the post-ack variant uses the incremented hold count so
  // the ack that exhausts the allowance already hands the bus over.
  always_comb begin
    others   = req & ~gnt_q;
    own_p    = prio[owner_q*PRIO_W +: PRIO_W];
    hi_other = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (others[j] && (prio[j*PRIO_W +: PRIO_W] > own_p)) hi_other = 1'b1;
    end
    hold_d        = (hold_q == HW'(HOLD_MAX)) ? hold_q : hold_q + 1'b1;
    preempt       = owner_valid && (hi_other || ((|others) && (hold_q >= HW'(HOLD_MAX))));
    pre_after_ack = owner_valid && (hi_other || ((|others) && (hold_d >= HW'(HOLD_MAX))));
    cs_own        = cyc_start[owner_q];
    req_own       = req[owner_q];
  end

  // Arbiter FSM with grant, owner, round-robin pointer and both counters.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= IW'(NREQ - 1);
      hold_q  <= '0;
      to_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            state_q <= ST_GRANTED;
            gnt_q   <= NREQ'(1) << win_idx;
            owner_q <= win_idx;
            rr_q    <= win_idx;
            hold_q  <= '0;
            to_q    <= '0;
          end
        end
        ST_GRANTED: begin
          if (cs_own) begin
            state_q <= ST_CYCLE;
            to_q    <= '0;
          end else if (!req_own || preempt || (to_q == TOW'(GRANT_TO - 1))) begin
            state_q <= ST_RELEASE;
            gnt_q   <= '0;
            owner_q <= '0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        ST_CYCLE: begin
          if (ack) begin
            hold_q <= hold_d;
            if (req_own && !pre_after_ack) begin
              state_q <= ST_GRANTED;
            end else begin
              state_q <= ST_RELEASE;
              gnt_q   <= '0;
              owner_q <= '0;
            end
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign owner_valid = |gnt_q;
  assign bus_busy    = (state_q == ST_CYCLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with fixed
// expectations, then a randomized run against a behavioural model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int HM = 8;
  localparam int GT = 16;

  localparam int PH_IDLE = 0;
  localparam int PH_GNT  = 1;
  localparam int PH_CYC  = 2;
  localparam int PH_REL  = 3;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*PW-1:0] prio = '0;
  logic [N-1:0]  cyc_start = '0;
  logic          ack = 1'b0;
  logic [N-1:0]  gnt;
  logic [1:0]    owner;
  logic          owner_valid, bus_busy, preempt;

  int n_chk  = 0;
  int n_fail = 0;

  bus_arbiter #(.NREQ(N), .PRIO_W(PW), .HOLD_MAX(HM), .GRANT_TO(GT)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .req         (req),
    .prio        (prio),
    .cyc_start   (cyc_start),
    .ack         (ack),
    .gnt         (gnt),
    .owner       (owner),
    .owner_valid (owner_valid),
    .bus_busy    (bus_busy),
    .preempt     (preempt)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- behavioural reference model ----------------
  function automatic int pr(input logic [N*PW-1:0] p, input int i);
    return int'(p[i*PW +: PW]);
  endfunction

  // Highest priority wins; equal priorities go to the first one met when
  // walking the ring from the master after the last winner. -1 if none.
  function automatic int mdl_pick(input logic [N-1:0] r, input logic [N*PW-1:0] p, input int rr);
    int best = -1;
    for (int k = 1; k <= N; k++) begin
      int i = (rr + k) % N;
      if (r[i] && (best < 0 || pr(p, i) > pr(p, best))) best = i;
    end
    return best;
  endfunction

  function automatic bit mdl_pre(input logic [N-1:0] r, input logic [N*PW-1:0] p,
                                 input int own, input bit ov, input int hold);
    if (!ov) return 1'b0;
    for (int j = 0; j < N; j++) begin
      if (j != own && r[j]) begin
        if (pr(p, j) > pr(p, own)) return 1'b1;
        if (hold >= HM) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  int m_ph = PH_IDLE, m_own = 0, m_rr = N - 1, m_hold = 0, m_to = 0;
  bit m_ov = 1'b0;
  int m_win;
  assign m_win = mdl_pick(req, prio, m_rr);

  always @(posedge sys_clk) begin
    if (reset) begin
      m_ph <= PH_IDLE; m_own <= 0; m_ov <= 1'b0; m_rr <= N - 1; m_hold <= 0; m_to <= 0;
    end else begin
      case (m_ph)
        PH_IDLE: if (m_win >= 0) begin
          m_ph <= PH_GNT; m_own <= m_win; m_ov <= 1'b1; m_rr <= m_win; m_hold <= 0; m_to <= 0;
        end
        PH_GNT: begin
          if (cyc_start[m_own]) begin
            m_ph <= PH_CYC; m_to <= 0;
          end else if (!req[m_own] || mdl_pre(req, prio, m_own, m_ov, m_hold) || (m_to + 1 == GT)) begin
            m_ph <= PH_REL; m_ov <= 1'b0; m_own <= 0;
          end else begin
            m_to <= m_to + 1;
          end
        end
        PH_CYC: if (ack) begin
          m_hold <= (m_hold < HM) ? m_hold + 1 : HM;
          if (req[m_own] && !mdl_pre(req, prio, m_own, 1'b1, (m_hold < HM) ? m_hold + 1 : HM))
            m_ph <= PH_GNT;
          else begin
            m_ph <= PH_REL; m_ov <= 1'b0; m_own <= 0;
          end
        end
        default: m_ph <= PH_IDLE;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] eg, input logic [1:0] eo,
                         input logic ev, input logic eb);
    chk({tag, "_gnt"},   32'(gnt),         32'(eg));
    chk({tag, "_owner"}, 32'(owner),       32'(eo));
    chk({tag, "_valid"}, 32'(owner_valid), 32'(ev));
    chk({tag, "_busy"},  32'(bus_busy),    32'(eb));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; cyc_start = '0; ack = 1'b0;
    cyc(1);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    cyc(2);
    #1 chk("rst_pre", 32'(preempt), 0);
    chk_out("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Single master: grant latency, five cycles, release on drop
    req = 4'b0010;
    cyc(1);
    chk_out("single_gnt", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc_start = 4'b0010;
      cyc(1);
      cyc_start = '0;
      chk("single_busy", 32'(bus_busy), 1);
      ack = 1'b1;
      #1 chk("single_pre", 32'(preempt), 0);
      cyc(1);
      ack = 1'b0;
      chk_out("single_back", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req = '0;
    cyc(1);
    chk_out("single_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(1);

    // Priority: master 3 beats master 0, handover dead time, then preemption
    do_reset();
    prio = 8'b11_00_00_00;
    req  = 4'b1001;
    cyc(1);
    chk_out("prio_gnt", 4'b1000, 2'd3, 1'b1, 1'b0);
    #1 chk("prio_nopre", 32'(preempt), 0);
    cyc_start = 4'b1000;
    cyc(1);
    cyc_start = '0;
    ack = 1'b1; req = 4'b0001;
    cyc(1);
    ack = 1'b0;
    chk_out("prio_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(1);
    chk("prio_idle", 32'(gnt), 0);
    cyc(1);
    chk_out("prio_gnt0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b1001;
    #1 chk("prio_pre", 32'(preempt), 1);
    cyc(1);
    req = '0;
    chk("prio_preempted", 32'(gnt), 0);
    cyc(2);

    // Round-robin among equal priorities
    do_reset();
    prio = 8'b01_01_01_01;
    req  = 4'b1111;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
      #1 chk("rr_pre", 32'(preempt), 0);
      cyc_start = gnt;
      cyc(1);
      cyc_start = '0;
      ack = 1'b1; req = 4'b1111 & ~(4'b0001 << (i % 4));
      cyc(1);
      ack = 1'b0; req = 4'b1111;
      cyc(2);
    end

    // Hold limit with an equal-priority waiter
    do_reset();
    prio = '0;
    req  = 4'b0011;
    cyc(1);
    chk("hold_gnt", 32'(gnt), 32'(4'b0001));
    for (int k = 1; k <= HM; k++) begin
      cyc_start = 4'b0001;
      cyc(1);
      cyc_start = '0;
      chk("hold_busy", 32'(bus_busy), 1);
      ack = 1'b1;
      #1 chk("hold_pre_low", 32'(preempt), 0);
      cyc(1);
      ack = 1'b0;
      chk("hold_after_ack", 32'(gnt), (k < HM) ? 32'(4'b0001) : 32'(0));
    end
    cyc(1);
    chk("hold_dead", 32'(gnt), 0);
    cyc(1);
    chk_out("hold_next", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Lone requester saturates its hold count, then a newcomer preempts it
    do_reset();
    req = 4'b0001;
    cyc(1);
    for (int k = 0; k < HM + 1; k++) begin
      cyc_start = 4'b0001;
      cyc(1);
      cyc_start = '0; ack = 1'b1;
      #1 chk("lone_pre", 32'(preempt), 0);
      cyc(1);
      ack = 1'b0;
    end
    chk("lone_still", 32'(gnt), 32'(4'b0001));
    req = 4'b0011;
    #1 chk("lone_pre_hi", 32'(preempt), 1);
    cyc(1);
    chk("lone_rel", 32'(gnt), 0);
    cyc(2);
    chk("lone_rr", 32'(gnt), 32'(4'b0010));

    // Grant timeout and re-grant
    do_reset();
    req = 4'b0100;
    cyc(1);
    chk("to_gnt", 32'(gnt), 32'(4'b0100));
    for (int t = 1; t < GT; t++) begin
      cyc(1);
      chk("to_hold", 32'(gnt), 32'(4'b0100));
    end
    cyc(1);
    chk("to_rel", 32'(gnt), 0);
    cyc(2);
    chk_out("to_regnt", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Reset mid-cycle, then a stray ack
    cyc_start = 4'b0100;
    cyc(1);
    cyc_start = '0;
    chk("rstmid_busy", 32'(bus_busy), 1);
    reset = 1'b1;
    cyc(1);
    chk_out("rstmid", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0; req = '0; ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk_out("stray_ack", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      chk_out("rnd", m_ov ? (4'b0001 << m_own) : 4'b0000, m_ov ? 2'(m_own) : 2'd0,
              m_ov, (m_ph == PH_CYC));
      if (c % 300 == 0) prio = 8'($urandom);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      cyc_start = 4'($urandom & $urandom);
      ack       = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      #1 chk("rnd_pre", 32'(preempt), 32'(mdl_pre(req, prio, m_own, m_ov, m_hold)));
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
